// File: rtl/inst_dispatch_buffer_pkg.sv
// ============================================================================
// Module   : inst_dispatch_buffer_pkg
// Brief    : Shared instruction-record field widths and packed record type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_dispatch_buffer_pkg;

  localparam int OPC_W    = 12;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 16;
  localparam int ADDR26_W = 26;
  localparam int PC_W     = 32;
  localparam int REC_W    = OPC_W + 4 * REG_W + IMM_W + ADDR26_W + PC_W;

  typedef struct packed {
    logic [OPC_W-1:0]    opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    shamt;
    logic [IMM_W-1:0]    immediate;
    logic [ADDR26_W-1:0] address;
    logic [PC_W-1:0]     pc;
  } inst_rec_t;

endpackage

`default_nettype wire

// File: rtl/inst_dispatch_buffer_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Show-ahead synchronous FIFO with flush; strobes arrive pre-gated.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = mem[r_rd_ptr];
  assign full    = (r_count == C_DEPTH);
  assign empty   = (r_count == '0);
  assign count   = r_count;

endmodule

`default_nettype wire

// File: rtl/inst_dispatch_buffer.sv
// ============================================================================
// Module   : inst_dispatch_buffer
// Brief    : Buffers decoded instruction records and issues them in order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_dispatch_buffer
  import inst_dispatch_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPC_W-1:0]    in_opcode,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [REG_W-1:0]    in_rt,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_shamt,
  input  logic [IMM_W-1:0]    in_immediate,
  input  logic [ADDR26_W-1:0] in_address,
  input  logic [PC_W-1:0]     in_pc,
  input  logic                in_valid,
  input  logic                flush,
  input  logic                issue_ready,
  output logic                fetch_stall,
  output logic                issue_valid,
  output logic [OPC_W-1:0]    issue_opcode,
  output logic [REG_W-1:0]    issue_rs,
  output logic [REG_W-1:0]    issue_rt,
  output logic [REG_W-1:0]    issue_rd,
  output logic [REG_W-1:0]    issue_shamt,
  output logic [IMM_W-1:0]    issue_immediate,
  output logic [ADDR26_W-1:0] issue_address,
  output logic [PC_W-1:0]     issue_pc,
  output logic [ADDR_W:0]     occupancy
);

  inst_rec_t w_in_rec;
  inst_rec_t w_head_rec;
  logic      w_full;
  logic      w_empty;
  logic      w_push;
  logic      w_pop;

  assign w_in_rec = '{opcode: in_opcode, rs: in_rs, rt: in_rt, rd: in_rd,
                      shamt: in_shamt, immediate: in_immediate,
                      address: in_address, pc: in_pc};

  // Stall comes from the registered count, so a same-cycle pop never frees a slot early.
  assign w_push = in_valid & ~w_full & ~flush;
  assign w_pop  = ~w_empty & issue_ready & ~flush;

  sync_fifo #(
    .WIDTH  (REC_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (w_push),
    .pop     (w_pop),
    .wr_data (w_in_rec),
    .rd_data (w_head_rec),
    .full    (w_full),
    .empty   (w_empty),
    .count   (occupancy)
  );

  assign fetch_stall     = w_full;
  assign issue_valid     = ~w_empty;
  assign issue_opcode    = w_head_rec.opcode;
  assign issue_rs        = w_head_rec.rs;
  assign issue_rt        = w_head_rec.rt;
  assign issue_rd        = w_head_rec.rd;
  assign issue_shamt     = w_head_rec.shamt;
  assign issue_immediate = w_head_rec.immediate;
  assign issue_address   = w_head_rec.address;
  assign issue_pc        = w_head_rec.pc;

endmodule

`default_nettype wire

// File: tb/tb_inst_dispatch_buffer.sv
// ============================================================================
// Module   : tb_inst_dispatch_buffer
// Brief    : Randomized self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_dispatch_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [11:0] in_opcode;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_immediate;
  logic [25:0] in_address;
  logic [31:0] in_pc;
  logic        in_valid, flush, issue_ready;
  logic        fetch_stall, issue_valid;
  logic [11:0] issue_opcode;
  logic [4:0]  issue_rs, issue_rt, issue_rd, issue_shamt;
  logic [15:0] issue_immediate;
  logic [25:0] issue_address;
  logic [31:0] issue_pc;
  logic [2:0]  occupancy;

  inst_dispatch_buffer #(.DEPTH(DEPTH), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_immediate(in_immediate), .in_address(in_address),
    .in_pc(in_pc), .in_valid(in_valid), .flush(flush), .issue_ready(issue_ready),
    .fetch_stall(fetch_stall), .issue_valid(issue_valid),
    .issue_opcode(issue_opcode), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rd(issue_rd), .issue_shamt(issue_shamt),
    .issue_immediate(issue_immediate), .issue_address(issue_address),
    .issue_pc(issue_pc), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: records in arrival order, layout {opc,rs,rt,rd,shamt,imm,addr,pc}.
  logic [105:0] model_q[$];

  task automatic check(input string tag, input logic [105:0] got, input logic [105:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [105:0] head_rec();
    return {issue_opcode, issue_rs, issue_rt, issue_rd, issue_shamt,
            issue_immediate, issue_address, issue_pc};
  endfunction

  task automatic check_state();
    check("occupancy", 106'(occupancy), 106'(model_q.size()));
    check("fetch_stall", 106'(fetch_stall), 106'(model_q.size() == DEPTH));
    check("issue_valid", 106'(issue_valid), 106'(model_q.size() != 0));
    if (model_q.size() != 0) check("issue_rec", head_rec(), model_q[0]);
  endtask

  // Called on a negedge: check, drive one cycle of inputs, advance model across the posedge.
  task automatic step(input bit v, input logic [31:0] pc, input bit fl, input bit rdy,
                      output bit pushed);
    logic [105:0] rec;
    bit do_push, do_pop;
    check_state();
    rec = {12'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom), pc};
    {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_immediate, in_address, in_pc} = rec;
    in_valid    = v;
    flush       = fl;
    issue_ready = rdy;
    do_push = v && (model_q.size() < DEPTH) && !fl;
    do_pop  = (model_q.size() != 0) && rdy && !fl;
    if (fl) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(rec);
    end
    pushed = do_push;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit p;
    int pc;
    int guard;
    bit tog;
    rst = 1'b0; in_valid = 1'b1; flush = 1'b0; issue_ready = 1'b0;
    {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_immediate, in_address, in_pc} = '0;

    // Reset held with in_valid asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_issue_valid", 106'(issue_valid), 106'(0));
    check("rst_fetch_stall", 106'(fetch_stall), 106'(0));
    check("rst_occupancy", 106'(occupancy), 106'(0));
    rst = 1'b1;
    step(1, 32'd0, 0, 0, p);
    step(0, 32'd0, 0, 1, p);

    // Fill to full, then hold pc=4 while stalled, then drain
    for (int i = 0; i < 4; i++) step(1, 32'(i), 0, 0, p);
    for (int i = 0; i < 3; i++) step(1, 32'd4, 0, 0, p);
    pc = 4; guard = 0;
    while (pc < 5 && guard < 20) begin
      step(1, 32'(pc), 0, 1, p);
      if (p) pc++;
      guard++;
    end
    repeat (6) step(0, 32'd0, 0, 1, p);

    // Wrap: ten records with ready toggling
    pc = 0; tog = 1; guard = 0;
    while (pc < 10 && guard < 100) begin
      step(1, 32'(pc), 0, tog, p);
      if (p) pc++;
      tog = !tog;
      guard++;
    end
    repeat (6) step(0, 32'd0, 0, 1, p);

    // Simultaneous push/pop at occupancy 2
    step(1, 32'd30, 0, 0, p);
    step(1, 32'd31, 0, 0, p);
    step(1, 32'd32, 0, 1, p);
    step(1, 32'd33, 0, 1, p);

    // Flush at occupancy 3 with a live push and pop
    repeat (2) step(0, 32'd0, 0, 1, p);
    for (int i = 0; i < 3; i++) step(1, 32'(40 + i), 0, 0, p);
    step(1, 32'd7, 1, 1, p);
    step(1, 32'd20, 0, 0, p);
    step(1, 32'd21, 0, 1, p);
    repeat (3) step(0, 32'd0, 0, 1, p);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, 32'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, p);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 32'(100 + i), 0, 0, p);
    #2 rst = 1'b0;
    #1;
    check("async_rst_occupancy", 106'(occupancy), 106'(0));
    check("async_rst_issue_valid", 106'(issue_valid), 106'(0));
    check("async_rst_fetch_stall", 106'(fetch_stall), 106'(0));
    model_q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1, 32'd200, 0, 0, p);
    step(0, 32'd0, 0, 1, p);
    step(0, 32'd0, 0, 0, p);
    check_state();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
